// File: rtl/s2mm_load_ab.sv
// AXI-Stream S2MM operand loader: scatters row-major beats round-robin across
// N1 BRAM write ports (beat i -> bank i mod N1, address i div N1).
module s2mm_load_ab #(
  parameter int unsigned D_W          = 32,
  parameter int unsigned N1           = 4,
  parameter int unsigned MATRIXSIZE_W = 16,
  parameter int unsigned ADDR_W       = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic [MATRIXSIZE_W-1:0] LEN,
  input  logic [31:0]             s_axis_s2mm_tdata,
  input  logic                    s_axis_s2mm_tvalid,
  input  logic                    s_axis_s2mm_tlast,
  output logic                    s_axis_s2mm_tready,
  output logic [N1-1:0]           wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [D_W-1:0]          wr_data,
  output logic [MATRIXSIZE_W-1:0] beat_cnt,
  output logic                    done_load,
  output logic                    err_tlast
);

  localparam int unsigned BANK_W = (N1 > 1) ? $clog2(N1) : 1;
  localparam int unsigned CMP_W  = MATRIXSIZE_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state_q,  state_d;
  logic [MATRIXSIZE_W-1:0] len_q,    len_d;
  logic [MATRIXSIZE_W-1:0] cnt_q,    cnt_d;
  logic [BANK_W-1:0]       bank_q,   bank_d;
  logic [ADDR_W-1:0]       addr_q,   addr_d;
  logic                    tready_q, tready_d;
  logic [N1-1:0]           wr_en_q,  wr_en_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [D_W-1:0]          wr_data_q, wr_data_d;
  logic                    done_q,   done_d;
  logic                    err_q,    err_d;

  logic             accept_c;
  logic [CMP_W-1:0] cnt_inc_c;
  logic             last_beat_c;

  // Extra bit keeps beat_cnt+1 exact when LEN is all ones
  assign cnt_inc_c   = {1'b0, cnt_q} + CMP_W'(1);
  assign last_beat_c = (cnt_inc_c == {1'b0, len_q});
  assign accept_c    = (state_q == S_LOAD) && s_axis_s2mm_tvalid && tready_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          len_d  = LEN;
          cnt_d  = '0;
          bank_d = '0;
          addr_d = '0;
          err_d  = 1'b0;
          if (LEN == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
            done_d  = 1'b0;
          end
        end
      end
      S_LOAD: begin
        if (accept_c) begin
          wr_en_d   = N1'(1) << bank_q;
          wr_addr_d = addr_q;
          wr_data_d = s_axis_s2mm_tdata[D_W-1:0];
          cnt_d     = cnt_inc_c[MATRIXSIZE_W-1:0];
          if (bank_q == BANK_W'(N1 - 1)) begin
            bank_d = '0;
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            bank_d = bank_q + BANK_W'(1);
          end
          // Either tlast or the length ends the load; only both together is clean
          if (s_axis_s2mm_tlast || last_beat_c) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = !(s_axis_s2mm_tlast && last_beat_c);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    tready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      bank_q    <= '0;
      addr_q    <= '0;
      tready_q  <= 1'b0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      tready_q  <= tready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign s_axis_s2mm_tready = tready_q;
  assign wr_en              = wr_en_q;
  assign wr_addr            = wr_addr_q;
  assign wr_data            = wr_data_q;
  assign beat_cnt           = cnt_q;
  assign done_load          = done_q;
  assign err_tlast          = err_q;

endmodule

// File: tb/tb_s2mm_load_ab.sv
// Bench for s2mm_load_ab: directed and random loads checked against a
// beat-index model (bank = i mod N1, addr = i div N1).
module tb_s2mm_load_ab;

  localparam int unsigned D_W          = 32;
  localparam int unsigned N1           = 4;
  localparam int unsigned MATRIXSIZE_W = 16;
  localparam int unsigned ADDR_W       = 12;

  logic                    clk;
  logic                    rst;
  logic                    arm;
  logic [MATRIXSIZE_W-1:0] len_in;
  logic [31:0]             tdata;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;
  logic [N1-1:0]           wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [D_W-1:0]          wr_data;
  logic [MATRIXSIZE_W-1:0] beat_cnt;
  logic                    done_load;
  logic                    err_tlast;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] stream_data;

  s2mm_load_ab #(
    .D_W(D_W), .N1(N1), .MATRIXSIZE_W(MATRIXSIZE_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .arm                (arm),
    .LEN                (len_in),
    .s_axis_s2mm_tdata  (tdata),
    .s_axis_s2mm_tvalid (tvalid),
    .s_axis_s2mm_tlast  (tlast),
    .s_axis_s2mm_tready (tready),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .beat_cnt           (beat_cnt),
    .done_load          (done_load),
    .err_tlast          (err_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One load: arm with len, offer up to `offer` beats, tlast on beat index
  // tlast_at (-1 = never). vmode 0 continuous, 1 alternating, 2 random.
  // arm_mid >= 0 pulses a bogus arm on that cycle; abort_at >= 0 returns right
  // after that many accepts.
  task automatic run(input int len, input int offer, input int tlast_at,
                     input int vmode, input int arm_mid, input int abort_at);
    int  target;
    int  acc;
    int  tail;
    int  cyc;
    bit  v;
    bit  exp_rdy;
    bit  take;
    logic [N1-1:0] exp_en;
    target = (tlast_at >= 0 && tlast_at < len) ? tlast_at + 1 : len;
    acc  = 0;
    tail = 0;
    @(negedge clk);
    arm    = 1'b1;
    len_in = MATRIXSIZE_W'(len);
    tvalid = 1'b0;
    tlast  = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      exp_rdy = (acc < target);
      check("tready", tready, exp_rdy);
      check("done_load", done_load, !exp_rdy);
      check("beat_cnt", beat_cnt, acc);
      if (!exp_rdy && tail >= 3) break;
      v = (acc + tail < offer || (!exp_rdy && acc < offer)) &&
          (vmode == 0 ? 1'b1 : vmode == 1 ? (cyc % 2 == 0) : bit'($urandom % 2));
      tvalid = v;
      tdata  = stream_data;
      tlast  = v && (acc == tlast_at);
      if (cyc == arm_mid) begin
        arm    = 1'b1;
        len_in = MATRIXSIZE_W'(len + 3);
      end
      take = v && exp_rdy;
      @(posedge clk);
      #1;
      if (take) begin
        exp_en = N1'(1) << (acc % N1);
        check("wr_en", wr_en, exp_en);
        check("wr_addr", wr_addr, acc / N1);
        check("wr_data", wr_data, stream_data);
        acc++;
        stream_data = $urandom;
        check("done_on_last_write", done_load, acc == target);
        if (acc == abort_at) return;
      end else begin
        check("wr_en_idle", wr_en, 0);
      end
      if (!exp_rdy) tail++;
      @(negedge clk);
      arm    = 1'b0;
      len_in = MATRIXSIZE_W'(len);
    end
    if (cyc >= 400) check("timeout_beats", acc, target);
    check("err_tlast", err_tlast, (len != 0) && (tlast_at != len - 1));
    arm    = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  initial begin
    int l;
    int t;
    rst = 1'b1;
    arm = 1'b0;
    len_in = '0;
    tdata = '0;
    tvalid = 1'b0;
    tlast = 1'b0;
    stream_data = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_tready", tready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_done", done_load, 0);
    check("rst_err", err_tlast, 0);
    rst = 1'b0;

    // Aligned 8-beat load, continuous valid
    run(8, 8, 7, 0, -1, -1);
    // Ragged 6-beat load with valid gaps
    run(6, 6, 5, 1, -1, -1);
    // Early tlast on beat 3
    run(8, 8, 3, 0, -1, -1);
    // Missing tlast; held-off 5th beat lands in bank 0 addr 0 of the next load
    run(4, 6, -1, 0, -1, -1);
    run(2, 2, 1, 0, -1, -1);
    // Zero-length load, then arm ignored mid-load
    run(0, 2, -1, 0, -1, -1);
    run(8, 8, 7, 0, 2, -1);

    for (int i = 0; i < 5; i++) begin
      l = 1 + int'($urandom % 20);
      case ($urandom % 3)
        0:       t = l - 1;
        1:       t = int'($urandom % l);
        default: t = -1;
      endcase
      run(l, l + 2, t, 2, -1, -1);
    end

    // Async reset mid-load, then a clean load
    run(8, 8, 7, 0, -1, 3);
    #1 rst = 1'b1;
    #1;
    check("midrst_tready", tready, 0);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_done", done_load, 0);
    check("midrst_beat_cnt", beat_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    tvalid = 1'b0;
    run(4, 4, 3, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/s2mm_load_ab.md
Name: s2mm_load_ab

Overview:
- AXI-Stream slave that receives a row-major operand matrix (A or B) from DMA S2MM and scatters the beats round-robin into N1 BRAM write ports feeding the systolic array.
- Mirror of the result-drain path: beat i is written to bank (i mod N1), address (i div N1).
- Once armed, counts exactly LEN beats, checks tlast alignment, then raises done_load for the compute controller.

Parameters:
- D_W, 32, BRAM word width; written data is tdata[D_W-1:0], D_W ≤ 32.
- N1, 4, number of banks (systolic rows); any value ≥ 1, not restricted to a power of 2.
- MATRIXSIZE_W, 16, width of the length and count fields.
- ADDR_W, 12, BRAM address width.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  one-cycle pulse that starts a load; honoured only in IDLE or DONE.
- LEN  in  MATRIXSIZE_W  total beats to load; sampled on arm.
- s_axis_s2mm_tdata  in  32  stream data.
- s_axis_s2mm_tvalid  in  1  stream valid.
- s_axis_s2mm_tlast  in  1  stream last.
- s_axis_s2mm_tready  out  1  stream ready.
- wr_en  out  N1  one-hot bank write enable.
- wr_addr  out  ADDR_W  shared write address.
- wr_data  out  D_W  shared write data.
- beat_cnt  out  MATRIXSIZE_W  beats accepted in the current load.
- done_load  out  1  level; load finished.
- err_tlast  out  1  level; tlast misaligned with LEN.

Behaviour:
- Reset (async assert, clear on the next clk edge after deassert): state=IDLE, tready=0, wr_en=0, wr_addr=0, wr_data=0, beat_cnt=0, done_load=0, err_tlast=0, len_q=0, bank_ptr=0, addr_ptr=0.
- FSM states: IDLE, LOAD, DONE.
- IDLE/DONE with arm=1:
  - Latch len_q=LEN.
  - Clear beat_cnt, bank_ptr, addr_ptr, done_load and err_tlast.
  - Go to LOAD. If LEN==0, go straight to DONE with done_load=1 and perform no writes.
- arm is ignored in LOAD.
- tready is registered: tready=1 for every cycle spent in LOAD, and 0 otherwise. It drops in the same cycle the state leaves LOAD, so no beat beyond len_q is ever accepted.
- Accept occurs when state==LOAD, tvalid=1 and tready=1. On accept, on the next edge:
  - wr_en = one-hot(bank_ptr); wr_addr = addr_ptr; wr_data = tdata[D_W-1:0].
  - Write latency is 1 cycle from the accept edge. wr_en is low in every cycle with no accept, and wr_addr/wr_data hold.
- Pointer update per accept:
  - If bank_ptr==N1-1: bank_ptr=0 and addr_ptr+=1; otherwise bank_ptr+=1.
  - addr_ptr wraps modulo 2^ADDR_W with no check; the caller guarantees LEN ≤ N1·2^ADDR_W.
  - beat_cnt+=1 per accept.
- Terminal beat, tlast=1 on the accepted beat:
  - If beat_cnt+1==len_q (aligned): go to DONE, done_load=1, err_tlast=0.
  - If beat_cnt+1<len_q (early tlast): the beat is still written; go to DONE, done_load=1, err_tlast=1.
- Terminal beat, tlast=0 on the accepted beat with beat_cnt+1==len_q (missing tlast): the beat is written; go to DONE with done_load=1 and err_tlast=1.
  - Stream beats that follow are not accepted (tready=0); DMA stalls until the next arm.
- DONE:
  - done_load and err_tlast hold until the next arm, which clears both in the same edge that enters LOAD.
  - The final wr_en pulse and the done_load assertion occur on the same edge.
- Ragged end: when LEN is not a multiple of N1, the last address row is partially written and unwritten banks keep old contents.
- Reset asserted mid-LOAD: immediate return to the reset state; partially written BRAM content is left as is; tready=0 asynchronously.
- tvalid low mid-packet: no state change; pointers hold.
- Width rule: the beat_cnt+1 comparison is done at MATRIXSIZE_W+1 bits so LEN=2^MATRIXSIZE_W-1 compares correctly.

Test Plan:
- N1=4, arm with LEN=8, 8 beats data 0..7 with tlast on beat 7, tvalid continuous -> wr_en sequence 1,2,4,8,1,2,4,8; wr_addr 0,0,0,0,1,1,1,1; done_load=1 on the edge of the last write; err_tlast=0; tready=0 afterwards.
- LEN=6, tvalid toggling 1010…, tlast on beat 5 -> banks 0..3 at addr 0, banks 0..1 at addr 1; no wr_en in gap cycles; beat_cnt=6; done_load=1.
- LEN=8, tlast on beat 3 -> 4 writes at addr 0, done_load=1, err_tlast=1, beat_cnt=4, beats 4..7 held off (tready=0).
- LEN=4 with no tlast, source offers 6 beats -> exactly 4 writes, err_tlast=1, the 5th beat is not accepted; arm with LEN=2 -> that 5th beat is accepted and written to bank 0 addr 0, err_tlast clears.
- arm with LEN=0 -> DONE next cycle, done_load=1, zero wr_en pulses; arm pulse during LOAD -> ignored, len_q and beat_cnt unchanged.
- Assert rst after 3 beats of LEN=8 -> tready, wr_en, done_load and beat_cnt all 0 immediately; after release, a fresh arm with LEN=4 writes banks 0..3 at addr 0.
